// File: rtl/fc_arb_pkg.sv
// Shared types for the FC output-neuron port-A arbiter.
// FSM states, grant selects, round-robin marks and a clog2 helper.
package fc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH,
        ST_READY
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } gnt_sel_t;

    localparam logic RR_READ  = 1'b0;
    localparam logic RR_WRITE = 1'b1;

    // Pointer width for a power-of-2 depth; never below 1 bit.
    function automatic int clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fc_wr_fifo.sv
// Write-back buffer: address/data FIFO with per-entry address and valid
// vectors for the read hazard compare. Ports: push/pop, head, full/empty/level.
module fc_wr_fifo
    import fc_arb_pkg::*;
#(
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int LW    = clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_push,
    input  logic [AW-1:0]       i_addr,
    input  logic [DW-1:0]       i_data,
    input  logic                i_pop,
    output logic [AW-1:0]       o_head_addr,
    output logic [DW-1:0]       o_head_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [LW-1:0]       o_level,
    output logic [DEPTH*AW-1:0] o_ent_addr,
    output logic [DEPTH-1:0]    o_ent_valid
);

    localparam int PW = clog2(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [PW-1:0] w_off;

    always_ff @(posedge clock) begin
        if (i_push) begin
            r_addr[r_wptr] <= i_addr;
            r_data[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally: DEPTH is a power of 2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !i_pop)      r_level <= r_level + 1'b1;
            else if (i_pop && !i_push) r_level <= r_level - 1'b1;
        end
    end

    // Entry i is occupied when its distance from the head is below level.
    always_comb begin
        o_ent_valid = '0;
        o_ent_addr  = '0;
        w_off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rptr;
            o_ent_valid[i] = ({1'b0, w_off} < r_level);
            o_ent_addr[i*AW +: AW] = r_addr[i];
        end
    end

    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_full      = (r_level == LW'(DEPTH));
    assign o_empty     = (r_level == '0);
    assign o_level     = r_level;

endmodule

// File: rtl/fc_outneuron_port_arbiter.sv
// Port-A owner for the FC output-neuron RAM: buffers write-back beats,
// arbitrates them against next-layer reads, and tracks layer completion.
module fc_outneuron_port_arbiter
    import fc_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int PO         = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH*PO-1:0]   wr_data,
    output logic                       wr_ready,
    input  logic                       layer_done,
    input  logic                       rd_req,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       rd_gnt,
    output logic                       rd_data_valid,
    output logic [ADDR_WIDTH-1:0]      ram_address_a,
    output logic [DATA_WIDTH*PO-1:0]   ram_data_a,
    output logic                       ram_wren_a,
    output logic                       ram_rden_a,
    output logic                       results_ready,
    output logic                       proto_err,
    output logic [clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = ADDR_WIDTH;
    localparam int BW = DATA_WIDTH * PO;
    localparam int LW = clog2(FIFO_DEPTH) + 1;

    arb_state_t             r_state;
    logic                   r_rr_last;
    logic                   r_wren;
    logic                   r_rden;
    logic [AW-1:0]          r_addr;
    logic [BW-1:0]          r_data;
    logic [RD_LATENCY-1:0]  r_rdv_sr;
    logic                   r_results_ready;
    logic                   r_proto_err;

    logic [AW-1:0]            w_head_addr;
    logic [BW-1:0]            w_head_data;
    logic                     w_full;
    logic                     w_empty;
    logic [LW-1:0]            w_level;
    logic [FIFO_DEPTH*AW-1:0] w_ent_addr;
    logic [FIFO_DEPTH-1:0]    w_ent_valid;
    logic                     w_hazard;
    logic                     w_rd_elig;
    logic                     w_wr_elig;
    logic                     w_push;
    logic                     w_pop;
    gnt_sel_t                 w_gnt;

    fc_wr_fifo #(
        .AW    (AW),
        .DW    (BW),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_addr      (wr_addr),
        .i_data      (wr_data),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level),
        .o_ent_addr  (w_ent_addr),
        .o_ent_valid (w_ent_valid)
    );

    // Includes the head even when it pops this cycle: the write is not
    // in RAM until the next cycle, so the read must still wait.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_ent_valid[i] && (w_ent_addr[i*AW +: AW] == rd_addr))
                w_hazard = 1'b1;
        end
    end

    assign w_rd_elig = rd_req && !w_hazard && (r_state != ST_FLUSH);
    assign w_wr_elig = !w_empty;

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_wr_elig && (w_full || r_state == ST_FLUSH))
            w_gnt = GNT_WR;
        else if (w_wr_elig && w_rd_elig)
            w_gnt = (r_rr_last == RR_WRITE) ? GNT_RD : GNT_WR;
        else if (w_wr_elig)
            w_gnt = GNT_WR;
        else if (w_rd_elig)
            w_gnt = GNT_RD;
    end

    assign wr_ready = !w_full && (r_state != ST_FLUSH);
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = (w_gnt == GNT_WR);
    assign rd_gnt   = (w_gnt == GNT_RD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_last <= RR_READ;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rdv_sr  <= '0;
        end else begin
            r_wren <= (w_gnt == GNT_WR);
            r_rden <= (w_gnt == GNT_RD);
            if (w_gnt == GNT_WR) begin
                r_addr    <= w_head_addr;
                r_data    <= w_head_data;
                r_rr_last <= RR_WRITE;
            end else if (w_gnt == GNT_RD) begin
                r_addr    <= rd_addr;
                r_rr_last <= RR_READ;
            end
            r_rdv_sr[0] <= r_rden;
            for (int i = 1; i < RD_LATENCY; i++)
                r_rdv_sr[i] <= r_rdv_sr[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_results_ready <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (layer_done) r_proto_err <= 1'b1;
                    if (wr_valid)   r_state     <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (layer_done) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (wr_valid || layer_done) r_proto_err <= 1'b1;
                    if (w_empty && (w_gnt != GNT_WR)) begin
                        r_state         <= ST_READY;
                        r_results_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (layer_done) r_proto_err <= 1'b1;
                    if (wr_valid) begin
                        r_state         <= ST_COLLECT;
                        r_results_ready <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_wren_a    = r_wren;
    assign ram_rden_a    = r_rden;
    assign ram_address_a = r_addr;
    assign ram_data_a    = r_data;
    assign rd_data_valid = r_rdv_sr[RD_LATENCY-1];
    assign results_ready = r_results_ready;
    assign proto_err     = r_proto_err;
    assign fifo_level    = w_level;

endmodule

// File: tb/tb_fc_outneuron_port_arbiter.sv
// Bench for the FC output-neuron port arbiter: directed scenarios then
// random traffic, compared against a queue-based reference model.
module tb_fc_outneuron_port_arbiter;

    localparam int AW = 7;
    localparam int BW = 32;
    localparam int DEPTH = 4;
    localparam int RL = 2;

    localparam int P_IDLE = 0;
    localparam int P_COLL = 1;
    localparam int P_FLSH = 2;
    localparam int P_RDY  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          layer_done = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_data_valid;
    logic [AW-1:0] ram_address_a;
    logic [BW-1:0] ram_data_a;
    logic          ram_wren_a;
    logic          ram_rden_a;
    logic          results_ready;
    logic          proto_err;
    logic [2:0]    fifo_level;

    fc_outneuron_port_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .layer_done    (layer_done),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_data_valid (rd_data_valid),
        .ram_address_a (ram_address_a),
        .ram_data_a    (ram_data_a),
        .ram_wren_a    (ram_wren_a),
        .ram_rden_a    (ram_rden_a),
        .results_ready (results_ready),
        .proto_err     (proto_err),
        .fifo_level    (fifo_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
    } ent_t;

    ent_t          q[$];
    int            due[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            phase = P_IDLE;
    bit            last_was_wr = 1'b0;
    logic          m_wren = 1'b0;
    logic          m_rden = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_data = '0;
    bit            m_err = 1'b0;
    int            peak = 0;
    bit            gnt_o;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a negedge; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        wr_valid = 0; layer_done = 0; rd_req = 0;
        #2 reset = 1'b0;
        q.delete(); due.delete();
        phase = P_IDLE; last_was_wr = 0; m_err = 0;
        m_wren = 0; m_rden = 0; m_addr = '0; m_data = '0;
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_results_ready", results_ready, 0);
        chk("rst_wren", ram_wren_a, 0);
        chk("rst_rden", ram_rden_a, 0);
        chk("rst_rdv", rd_data_valid, 0);
        chk("rst_addr", ram_address_a, 0);
        chk("rst_data", ram_data_a, 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock: drive, check combinational outputs, clock, check registers.
    task automatic step(input bit wv, input logic [AW-1:0] wa,
                        input logic [BW-1:0] wd, input bit ld,
                        input bit rq, input logic [AW-1:0] ra,
                        output bit granted);
        bit   hz, rd_ok, wr_ok, rdy, push, was_empty, rdv;
        int   g;
        ent_t e;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        layer_done = ld; rd_req = rq; rd_addr = ra;
        #1;
        hz = 0;
        foreach (q[i]) if (q[i].a == ra) hz = 1;
        rd_ok = rq && !hz && phase != P_FLSH;
        wr_ok = q.size() > 0;
        if (wr_ok && (q.size() == DEPTH || phase == P_FLSH)) g = 1;
        else if (wr_ok && rd_ok) g = last_was_wr ? 2 : 1;
        else if (wr_ok) g = 1;
        else if (rd_ok) g = 2;
        else g = 0;
        rdy = q.size() < DEPTH && phase != P_FLSH;
        push = wv && rdy;
        was_empty = q.size() == 0;
        chk("wr_ready", wr_ready, rdy);
        chk("rd_gnt", rd_gnt, g == 2);
        @(posedge clock);
        #1;
        cyc++;
        m_wren = (g == 1);
        m_rden = (g == 2);
        if (g == 1) begin
            e = q.pop_front();
            m_addr = e.a; m_data = e.d; last_was_wr = 1;
        end else if (g == 2) begin
            m_addr = ra; last_was_wr = 0;
            due.push_back(cyc + RL);
        end
        if (push) q.push_back('{a: wa, d: wd});
        case (phase)
            P_IDLE: begin
                if (ld) m_err = 1;
                if (wv) phase = P_COLL;
            end
            P_COLL: if (ld) phase = P_FLSH;
            P_FLSH: begin
                if (wv || ld) m_err = 1;
                if (was_empty) phase = P_RDY;
            end
            default: begin
                if (ld) m_err = 1;
                if (wv) phase = P_COLL;
            end
        endcase
        while (due.size() > 0 && due[0] < cyc) void'(due.pop_front());
        rdv = due.size() > 0 && due[0] == cyc;
        if (rdv) void'(due.pop_front());
        chk("ram_wren_a", ram_wren_a, m_wren);
        chk("ram_rden_a", ram_rden_a, m_rden);
        chk("ram_address_a", ram_address_a, m_addr);
        chk("ram_data_a", ram_data_a, m_data);
        chk("rd_data_valid", rd_data_valid, rdv);
        chk("results_ready", results_ready, phase == P_RDY);
        chk("proto_err", proto_err, m_err);
        chk("fifo_level", fifo_level, q.size());
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        granted = (g == 2);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit            rq;
        logic [AW-1:0] ra;
        int            n;
        @(negedge clock);
        do_reset();

        // Three writes, no reads: one write per cycle, level never above 1.
        peak = 0;
        for (int i = 0; i < 3; i++)
            step(1, AW'(i), 32'hA000_0000 + i, 0, 0, 0, gnt_o);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, gnt_o);
        chk("peak_level_3wr", peak, 1);

        // Four back-to-back writes against a held read of addr 9.
        for (int i = 0; i < 4; i++)
            step(1, AW'(16 + i), $urandom, 0, 1, 7'd9, gnt_o);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 7'd9, gnt_o);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, gnt_o);

        // Write addr 5 while reads compete, then a read of addr 5.
        step(1, 7'd5, 32'h5555_5555, 0, 1, 7'd9, gnt_o);
        n = 0;
        do begin
            step(0, 0, 0, 0, 1, 7'd5, gnt_o);
            n++;
        end while (!gnt_o && n < 20);
        chk("rd5_granted", gnt_o, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, gnt_o);

        // Fill the FIFO with reads held: writes win while full.
        for (int i = 0; i < 8; i++)
            step(1, AW'(32 + i), $urandom, 0, 1, 7'd40, gnt_o);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 7'd40, gnt_o);
        step(0, 0, 0, 0, 0, 0, gnt_o);

        // Last write with layer_done, reads blocked during flush.
        step(1, 7'd50, 32'hDEAD_BEEF, 0, 0, 0, gnt_o);
        step(1, 7'd51, 32'hCAFE_F00D, 1, 1, 7'd60, gnt_o);
        n = 0;
        while (!results_ready && n < 20) begin
            step(0, 0, 0, 0, 1, 7'd60, gnt_o);
            n++;
        end
        chk("results_ready_reached", results_ready, 1);
        step(0, 0, 0, 0, 0, 0, gnt_o);

        // Refill, flush, write during flush, then reset mid-flush.
        for (int i = 0; i < 6; i++)
            step(1, AW'(64 + i), $urandom, 0, 1, 7'd90, gnt_o);
        step(1, 7'd70, $urandom, 1, 1, 7'd90, gnt_o);
        step(1, 7'd71, $urandom, 0, 0, 0, gnt_o);
        chk("proto_err_flush_wr", proto_err, 1);
        chk("level_mid_flush_nonzero", fifo_level != 0, 1);
        do_reset();

        // Random traffic; reads are held until granted.
        rq = 0; ra = '0;
        for (int i = 0; i < 600; i++) begin
            if (!rq) begin
                rq = ($urandom_range(0, 2) == 0);
                ra = AW'($urandom_range(0, 7));
            end
            step($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 29) == 0, rq, ra, gnt_o);
            if (gnt_o) rq = 0;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                rq = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
